// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit and the instruction decoder.
//   MD_* : operation codes carried on the 'f' field
//   md_state_e : sequencing states of hilo_unit
package md_pkg;

  localparam logic [1:0] MD_DIV   = 2'd0;
  localparam logic [1:0] MD_DIVU  = 2'd1;
  localparam logic [1:0] MD_MULT  = 2'd2;
  localparam logic [1:0] MD_MULTU = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Per-iteration datapath for unsigned shift-add multiply and restoring divide.
// Ports:
//   clk_i, reset_i       : clock, synchronous active-high reset
//   load_i               : initialise accumulator, operand and counter
//   step_i               : perform one iteration
//   is_div_i             : 1 = divide step, 0 = multiply step
//   load_m_i             : multiplicand / divisor magnitude
//   load_lo_i            : multiplier / dividend magnitude
//   acc_hi_o, acc_lo_o   : accumulator (product, or remainder:quotient)
//   last_o               : the current step is the final iteration
module md_iter_core #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             is_div_i,
  input  logic [Width-1:0] load_m_i,
  input  logic [Width-1:0] load_lo_i,
  output logic [Width-1:0] acc_hi_o,
  output logic [Width-1:0] acc_lo_o,
  output logic             last_o
);

  localparam int unsigned CntW = $clog2(Width);

  logic [Width-1:0] acc_hi_q, acc_hi_d;
  logic [Width-1:0] acc_lo_q, acc_lo_d;
  logic [Width-1:0] m_q, m_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [Width:0]   mul_sum;
  logic [Width:0]   div_sh;
  logic             div_ge;
  logic [Width-1:0] div_diff;

  assign last_o   = (cnt_q == CntW'(Width - 1));
  assign acc_hi_o = acc_hi_q;
  assign acc_lo_o = acc_lo_q;

  always_comb begin
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;
    cnt_d    = cnt_q;

    // Multiply: add multiplicand when the current multiplier bit is set, then
    // shift {carry, hi, lo} right; multiplier bits drain out of lo as product bits fill it.
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);

    // Divide: shift next dividend bit into the partial remainder and trial-subtract.
    // The remainder stays below the divisor, so the difference fits in Width bits.
    div_sh   = {acc_hi_q, acc_lo_q[Width-1]};
    div_ge   = (div_sh >= {1'b0, m_q});
    div_diff = div_sh[Width-1:0] - m_q;

    if (load_i) begin
      acc_hi_d = '0;
      acc_lo_d = load_lo_i;
      m_d      = load_m_i;
      cnt_d    = '0;
    end else if (step_i) begin
      cnt_d = last_o ? '0 : cnt_q + CntW'(1);
      if (is_div_i) begin
        acc_hi_d = div_ge ? div_diff : div_sh[Width-1:0];
        acc_lo_d = {acc_lo_q[Width-2:0], div_ge};
      end else begin
        acc_hi_d = mul_sum[Width:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[Width-1:1]};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
    end else begin
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, f        : operation request and code (DIV/DIVU/MULT/MULTU)
//   op1, op2        : rs (dividend/multiplicand), rt (divisor/multiplier)
//   mthi, mtlo      : write op1 into HI / LO when idle
//   hi, lo          : HI/LO register contents
//   busy            : operation in flight
//   done            : one-cycle pulse when new HI/LO values first appear
module hilo_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       f,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             mthi,
  input  logic             mtlo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  md_state_e        state_q, state_d;
  logic             is_mul_q, is_mul_d;
  logic             neg_q, neg_d;       // quotient / product is negative
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;         // divide by zero
  logic [WIDTH-1:0] op1_q, op1_d;       // original dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             in_signed, in_div, s1, s2;
  logic [WIDTH-1:0] mag1, mag2;
  logic             core_load, core_step, core_last;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign in_signed = (f == MD_DIV) || (f == MD_MULT);
  assign in_div    = (f == MD_DIV) || (f == MD_DIVU);
  assign s1        = in_signed & op1[WIDTH-1];
  assign s2        = in_signed & op2[WIDTH-1];
  // Negating the most negative value yields 2^(WIDTH-1) read as unsigned, which
  // is the correct magnitude; this also makes MIN / -1 fall out as MIN, rem 0.
  assign mag1      = s1 ? -op1 : op1;
  assign mag2      = s2 ? -op2 : op2;

  assign core_step = (state_q == StRun);

  md_iter_core #(
    .Width(WIDTH)
  ) u_core (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (core_load),
    .step_i   (core_step),
    .is_div_i (~is_mul_q),
    .load_m_i (in_div ? mag2 : mag1),
    .load_lo_i(in_div ? mag1 : mag2),
    .acc_hi_o (acc_hi),
    .acc_lo_o (acc_lo),
    .last_o   (core_last)
  );

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_q ? -prod : prod;
  assign quo_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = rem_neg_q ? -acc_hi : acc_hi;

  always_comb begin
    state_d   = state_q;
    is_mul_d  = is_mul_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    op1_d     = op1_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    core_load = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          // start wins over a simultaneous mthi/mtlo
          state_d   = StRun;
          core_load = 1'b1;
          is_mul_d  = ~in_div;
          neg_d     = s1 ^ s2;
          rem_neg_d = s1;
          dz_d      = (op2 == '0);
          op1_d     = op1;
        end else begin
          if (mthi) hi_d = op1;
          if (mtlo) lo_d = op1;
        end
      end
      StRun: begin
        if (core_last) state_d = StFix;
      end
      StFix: begin
        if (is_mul_q) begin
          {hi_d, lo_d} = prod_fix;
        end else if (dz_q) begin
          hi_d = op1_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      is_mul_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      op1_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_mul_q  <= is_mul_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      op1_q     <= op1_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting in the execute stage beside the main ALU. It accepts MULT/MULTU/DIV/DIVU with two 32-bit operands, iterates one bit per cycle, and writes the 64-bit result into HI/LO. It also services MTHI/MTLO writes, exposes HI/LO for MFHI/MFLO, and raises `busy` so hazard logic stalls any HI/LO access until the result lands.

## Interface
- `WIDTH`, 32, operand/register width; must be even and ≥ 8.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request an operation; accepted only when `busy`=0.
- `f` in 2: operation code, valid with `start`: 0 DIV, 1 DIVU, 2 MULT, 3 MULTU.
- `op1` in WIDTH: rs operand (dividend / multiplicand).
- `op2` in WIDTH: rt operand (divisor / multiplier).
- `mthi`, `mtlo` in 1: write `op1` into HI / LO.
- `hi`, `lo` out WIDTH: HI/LO register contents.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse, the cycle in which new HI/LO values first become visible.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on `start`, latch `f`, the operand magnitudes (absolute values for DIV/MULT), and the result signs; clear the counter and accumulator; go to RUN.
- RUN: WIDTH iterations, one per cycle.
  - Multiply: shift-add over multiplier bits.
  - Divide: restoring, one quotient bit per cycle.
  - After iteration WIDTH-1, go to FIX.
- FIX:
  - Apply sign correction.
  - Multiply: the 2·WIDTH product goes to {HI,LO}.
  - Divide: LO = quotient, truncated toward zero; HI = remainder, with the sign of the dividend.
  - Write HI/LO, pulse `done` in the following cycle, return to IDLE.
- Divide by zero, signed or unsigned: LO = all ones, HI = `op1`. This is produced in FIX from a flag latched at start.
- Signed overflow DIV (−2^(WIDTH−1) / −1): LO = 0x80000000, HI = 0.
- `mthi`/`mtlo` when IDLE and `start`=0 write `op1` at the edge. Both asserted together write both registers.
- Requests ignored, with no effect on state:
  - `start`, `mthi` and `mtlo` while `busy`=1.
  - `mthi`/`mtlo` in the same cycle as an accepted `start`; `start` wins.
- `start` in the cycle `done` is high is accepted normally.
- Reset:
  - Values: HI=0, LO=0, `busy`=0, `done`=0, state IDLE, counter 0.
  - Reset mid-operation aborts the operation, with no partial HI/LO write.

## Timing
- Cycle 0 is the `start` edge. `busy`=1 from cycle 1 through cycle WIDTH+1 (33 cycles for WIDTH=32).
- HI/LO update at the edge ending the FIX cycle. `done`=1 and new values are visible in cycle WIDTH+2; `busy`=0 in that cycle.
- Outputs `hi`/`lo` are direct register outputs; they hold old values throughout `busy`.
- MTHI/MTLO: value visible the cycle after the write.
- `busy` and `done` are registered, with no combinational path from inputs.

## Structure
- A shared package `md_pkg` holds:
  - the op-code constants `MD_DIV`=0, `MD_DIVU`=1, `MD_MULT`=2, `MD_MULTU`=3, also used by the decoder;
  - the state enum {IDLE, RUN, FIX}.
- One sub-module, `md_iter_core`, holds the per-iteration datapath: accumulator/remainder register, shift, add/subtract, and counter.
- The FSM, sign handling, special cases and HI/LO registers stay in `hilo_unit`.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 33 busy cycles, `done`; HI=0xFFFFFFFE, LO=0x00000001.
- MULT −7 × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=100. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- MTHI 0x1234 while busy → ignored; HI after `done` equals the operation result. MTLO 0xABCD when idle → LO=0xABCD next cycle.
- Back-to-back: second `start` in the `done` cycle is accepted, `busy` stays 0 for only that cycle, and the second result arrives 34 cycles after the first.
- `reset` asserted at iteration 10 → next cycle `busy`=0, HI=LO=0, no `done`. A new MULTU 6 × 7 then gives LO=42, HI=0.
